// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: shared state type and data width for the FIFO transmit serializer
package fifo_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: counts 1..rollover_val and wraps to 1, with synchronous clear and a rollover flag
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);
    logic [NUM_CNT_BITS-1:0] count;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) count <= '0;
        else if (clear) count <= '0;
        else if (count_enable) count <= (count == rollover_val) ? NUM_CNT_BITS'(1) : count + 1'b1;
    assign rollover_flag = count == rollover_val;
endmodule

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops bytes from the output FIFO and shifts them out as serial frames
module fifo_tx_serializer import fifo_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_r_enable,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       byte_done
);
    tx_state_t state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic par, stop_cnt, bit_end, idx_last, stop_last, stop_end, pop, line_nxt;
    // the bit timer restarts whenever the next cycle is idle, so a pop always begins at count 1
    flex_counter #(.NUM_CNT_BITS(8)) u_bit_timer (
        .clk(clk), .n_rst(n_rst), .clear(state_nxt == IDLE), .count_enable(1'b1),
        .rollover_val(8'(CLKS_PER_BIT)), .rollover_flag(bit_end)
    );
    flex_counter #(.NUM_CNT_BITS(3)) u_bit_idx (
        .clk(clk), .n_rst(n_rst), .clear(state != DATA), .count_enable(bit_end),
        .rollover_val(3'(DATA_BITS - 1)), .rollover_flag(idx_last)
    );
    assign stop_last     = (STOP_BITS == 1) || stop_cnt;
    assign stop_end      = state == STOP && bit_end && stop_last;
    assign pop           = n_rst && !fifo_empty && (state == IDLE || stop_end);
    assign fifo_r_enable = pop;
    assign byte_done     = stop_end;
    assign tx_busy       = state != IDLE;
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = pop ? START : IDLE;
            START:   state_nxt = bit_end ? DATA : START;
            DATA:    state_nxt = (bit_end && idx_last) ? (PARITY_EN ? PARITY : STOP) : DATA;
            PARITY:  state_nxt = bit_end ? STOP : PARITY;
            STOP:    state_nxt = stop_end ? (pop ? START : IDLE) : STOP;
            default: state_nxt = IDLE;
        endcase
        shreg_nxt = pop ? fifo_data : (state == DATA && bit_end) ? shreg >> 1 : shreg;
        line_nxt  = state_nxt == START ? 1'b0 : state_nxt == DATA ? shreg_nxt[0] : state_nxt == PARITY ? par : 1'b1;
    end
    // line is registered from the next-state view so the start bit appears on the pop edge
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state      <= IDLE;
            shreg      <= '0;
            par        <= 1'b0;
            stop_cnt   <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            par        <= pop ? ^fifo_data : par;
            stop_cnt   <= state == STOP && (bit_end ? !stop_last : stop_cnt);
            serial_out <= line_nxt;
        end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: two serializers (8N1 and 8E2, 4 clk/bit) checked against a per-cycle line model
module tb_fifo_tx_serializer;
    logic clk = 1'b0;
    logic n_rst;
    logic [1:0] fifo_empty, fifo_r_enable, serial_out, tx_busy, byte_done, hold, pend;
    logic [1:0][7:0] fifo_data;
    logic [7:0] fq [2][$];
    logic exq [2][$];
    int checks = 0, failures = 0, pushed = 0;
    int pops [2], run [2], last_run [2], saved [2];
    bit drained;

    always #5 clk = ~clk;

    fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_r_enable(fifo_r_enable[0]), .serial_out(serial_out[0]), .tx_busy(tx_busy[0]), .byte_done(byte_done[0])
    );
    fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_r_enable(fifo_r_enable[1]), .serial_out(serial_out[1]), .tx_busy(tx_busy[1]), .byte_done(byte_done[1])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int d = 0; d < 2; d++) begin
            fifo_empty[d] = hold[d] || fq[d].size() == 0;
            fifo_data[d]  = fq[d].size() != 0 ? fq[d][0] : 8'($urandom);
        end
    endtask

    task automatic push(input logic [7:0] b);
        for (int d = 0; d < 2; d++) fq[d].push_back(b);
        pushed++;
        refresh();
    endtask

    // dut d: parity when d==1, d+1 stop bits; every bit lasts 4 clocks
    task automatic add_frame(input int d, input logic [7:0] b);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (d == 1) bits.push_back(^b);
        for (int s = 0; s <= d; s++) bits.push_back(1'b1);
        foreach (bits[i]) repeat (4) exq[d].push_back(bits[i]);
    endtask

    task automatic step();
        int n;
        logic x;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!n_rst) begin
                chk("rst_line", d, serial_out[d], 1);
                chk("rst_pop", d, fifo_r_enable[d], 0);
                chk("rst_busy", d, tx_busy[d], 0);
                chk("rst_done", d, byte_done[d], 0);
                exq[d].delete();
                run[d] = 0;
                pend[d] = 1'b0;
            end else begin
                n = exq[d].size();
                x = n != 0 ? exq[d][0] : 1'b1;
                chk("line", d, serial_out[d], x);
                chk("busy", d, tx_busy[d], n > 0);
                chk("done", d, byte_done[d], n == 1);
                chk("pop", d, fifo_r_enable[d], !fifo_empty[d] && n <= 1);
                chk("pop_when_empty", d, fifo_r_enable[d] & fifo_empty[d], 0);
                if (tx_busy[d]) run[d]++;
                else if (run[d] != 0) begin
                    last_run[d] = run[d];
                    run[d] = 0;
                end
                if (n != 0) void'(exq[d].pop_front());
                if (fifo_r_enable[d] && fq[d].size() != 0) begin
                    pops[d]++;
                    add_frame(d, fq[d][0]);
                    pend[d] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) if (pend[d]) begin
            void'(fq[d].pop_front());
            pend[d] = 1'b0;
        end
        refresh();
    endtask

    initial begin
        n_rst = 1'b0;
        hold = '0;
        pend = '0;
        for (int d = 0; d < 2; d++) begin
            pops[d] = 0; run[d] = 0; last_run[d] = 0;
        end
        push(8'hA5);
        repeat (4) step();
        n_rst = 1'b1;
        repeat (55) step();
        chk("single_pops", 0, pops[0], 1);
        chk("single_len", 0, last_run[0], 40);
        chk("single_len", 1, last_run[1], 48);

        push(8'h00); push(8'hFF); push(8'h3C);
        repeat (160) step();
        chk("stream_pops", 0, pops[0], 4);
        chk("stream_busy_len", 0, last_run[0], 120);
        chk("stream_busy_len", 1, last_run[1], 144);

        push(8'h07);
        repeat (60) step();
        chk("par07_len", 1, last_run[1], 48);
        push(8'h03);
        repeat (60) step();
        chk("par03_len", 1, last_run[1], 48);

        push(8'hC3);
        repeat (18) step();
        push(8'h5A);
        for (int d = 0; d < 2; d++) chk("pre_rst_bit3", d, serial_out[d], 0);
        #2 n_rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_line", d, serial_out[d], 1);
            chk("async_pop", d, fifo_r_enable[d], 0);
            saved[d] = pops[d];
        end
        repeat (3) step();
        n_rst = 1'b1;
        repeat (60) step();
        for (int d = 0; d < 2; d++) chk("post_rst_pops", d, pops[d], saved[d] + 1);
        chk("post_rst_len", 0, last_run[0], 40);
        chk("post_rst_len", 1, last_run[1], 48);

        push(8'($urandom)); push(8'($urandom));
        repeat (6) step();
        repeat (30) begin
            hold = 2'($urandom_range(0, 3));
            refresh();
            step();
        end
        hold = '0;
        refresh();
        repeat (120) step();

        repeat (12) push(8'($urandom));
        drained = 1'b0;
        for (int i = 0; i < 3000 && !drained; i++) begin
            hold = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
            refresh();
            step();
            drained = fq[0].size() == 0 && fq[1].size() == 0 && exq[0].size() == 0 && exq[1].size() == 0 && tx_busy == 2'b00;
        end
        chk("drain_in_budget", 0, drained, 1);
        for (int d = 0; d < 2; d++) chk("pop_total", d, pops[d], pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
